// File: rtl/dma_ext_pkg.sv
// dma_ext_pkg: shared types and constants for the DMA external device and its controller.
package dma_ext_pkg;

  localparam int unsigned DmaWordSize = 16;
  localparam int unsigned DmaBurstLen = 4;

  localparam int unsigned           LfsrWidth = 32;
  localparam logic [LfsrWidth-1:0] LfsrTaps  = 32'h80200003;

  typedef enum logic [2:0] {
    StIdle,
    StFire,
    StBusy,
    StRefill,
    StHalt,
    StInit
  } dma_ext_state_e;

  // One Galois step: shift right, fold the taps back in when a 1 falls out.
  function automatic logic [LfsrWidth-1:0] lfsr_step(input logic [LfsrWidth-1:0] s);
    logic [LfsrWidth-1:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ LfsrTaps;
    return n;
  endfunction

endpackage

// File: rtl/dma_ext_device_if.sv
// dma_ext_device_if: CPU/DMA-facing signals of dma_ext_device.
interface dma_ext_device_if
  import dma_ext_pkg::*;
#(
  parameter int unsigned WORD_SIZE = DmaWordSize,
  parameter int unsigned BURST_LEN = DmaBurstLen,
  parameter int unsigned OFFSET_W  = 2
);

  logic [OFFSET_W-1:0]            offset;
  logic                           int_ack;
  logic                           dma_done;
  logic                           interrupt;
  logic [BURST_LEN*WORD_SIZE-1:0] data;
  logic                           data_valid;
  logic                           rd_err;
  logic [7:0]                     missed;
  logic                           halted;

  modport master (
    output offset, int_ack, dma_done,
    input  interrupt, data, data_valid, rd_err, missed, halted
  );

  modport slave (
    input  offset, int_ack, dma_done,
    output interrupt, data, data_valid, rd_err, missed, halted
  );

endinterface

// File: rtl/dma_ext_lfsr.sv
// dma_ext_lfsr: 32-bit Galois LFSR with seed load and step enable; next_o is the value after one step.
module dma_ext_lfsr
  import dma_ext_pkg::*;
#(
  parameter logic [LfsrWidth-1:0] SEED = 32'h1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 step_i,
  output logic [LfsrWidth-1:0] next_o
);

  logic [LfsrWidth-1:0] state_q;

  assign next_o = lfsr_step(state_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SEED;
    end else if (load_i) begin
      state_q <= SEED;
    end else if (step_i) begin
      state_q <= next_o;
    end
  end

endmodule

// File: rtl/dma_ext_device.sv
// dma_ext_device: clocked external I/O device raising periodic DMA requests and serving block reads.
// Define DMA_EXT_DEVICE_LFSR_EN for LFSR-generated storage contents with an INIT fill after reset.
module dma_ext_device
  import dma_ext_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = DmaWordSize,
  parameter int unsigned BURST_LEN    = DmaBurstLen,
  parameter int unsigned NUM_BLOCKS   = 3,
  parameter int unsigned FIRE_PERIOD  = 260,
  parameter int unsigned INT_DURATION = 100,
  parameter int unsigned NUM_FIRES    = 2,
  parameter logic [31:0] SEED         = 32'h1
) (
  input logic             clk,
  input logic             reset,
  dma_ext_device_if.slave bus
);

  localparam int unsigned OFFSET_W = $clog2(NUM_BLOCKS + 1);
  localparam int unsigned BLK_W    = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int unsigned WRD_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned TMR_MAX  = (FIRE_PERIOD > INT_DURATION) ? FIRE_PERIOD : INT_DURATION;
  localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);
  localparam int unsigned FIRES_W  = $clog2(NUM_FIRES + 1);
  localparam int unsigned DATA_W   = BURST_LEN * WORD_SIZE;

`ifdef DMA_EXT_DEVICE_LFSR_EN
  localparam dma_ext_state_e ResetState = StInit;
`else
  localparam dma_ext_state_e ResetState = StIdle;
`endif

  dma_ext_state_e      state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [FIRES_W-1:0]  fires_q, fires_d;
  logic [7:0]          missed_q, missed_d;
  logic                irq_q, irq_d;
  logic                halted_q;

  logic [WORD_SIZE-1:0] mem_q [NUM_BLOCKS][BURST_LEN];
  logic [BLK_W-1:0]     wr_blk_q;
  logic [WRD_W-1:0]     wr_wrd_q;
  logic                 wr_en;
  logic [WORD_SIZE-1:0] wr_data;
  logic                 last_wrd, last_blk, last_word;

  logic [DATA_W-1:0] data_q;
  logic              data_valid_q, rd_err_q;
  logic [BLK_W-1:0]  rd_blk;
  logic [DATA_W-1:0] rd_block;

  assign last_wrd  = (wr_wrd_q == WRD_W'(BURST_LEN - 1));
  assign last_blk  = (wr_blk_q == BLK_W'(NUM_BLOCKS - 1));
  assign last_word = last_wrd && last_blk;

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    fires_d  = fires_q;
    missed_d = missed_q;
    irq_d    = irq_q;
    wr_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (timer_q == TMR_W'(FIRE_PERIOD - 1)) begin
          state_d = StFire;
          timer_d = '0;
          irq_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StFire: begin
        // Ack takes priority over a timeout landing on the same cycle.
        if (bus.int_ack) begin
          state_d = StBusy;
          timer_d = '0;
          irq_d   = 1'b0;
        end else if (timer_q == TMR_W'(INT_DURATION - 1)) begin
          missed_d = (missed_q == 8'hff) ? missed_q : missed_q + 8'd1;
          state_d  = StRefill;
          timer_d  = '0;
          irq_d    = 1'b0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StBusy: begin
        if (bus.dma_done) state_d = StRefill;
      end
      StRefill: begin
        wr_en = 1'b1;
        if (last_word) begin
          fires_d = fires_q + 1'b1;
          if (fires_q == FIRES_W'(NUM_FIRES - 1)) begin
            state_d = StHalt;
          end else begin
            state_d = StIdle;
            timer_d = '0;
          end
        end
      end
      StHalt: begin
        irq_d = 1'b0;
      end
`ifdef DMA_EXT_DEVICE_LFSR_EN
      StInit: begin
        wr_en = 1'b1;
        if (last_word) begin
          state_d = StIdle;
          timer_d = '0;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ResetState;
      timer_q  <= '0;
      fires_q  <= '0;
      missed_q <= '0;
      irq_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      fires_q  <= fires_d;
      missed_q <= missed_d;
      irq_q    <= irq_d;
      halted_q <= (state_d == StHalt);
    end
  end

  // Refill walks the storage block-major, word 0 first, wrapping back to 0 after the last word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_blk_q <= '0;
      wr_wrd_q <= '0;
    end else if (wr_en) begin
      if (last_wrd) begin
        wr_wrd_q <= '0;
        wr_blk_q <= last_blk ? '0 : wr_blk_q + 1'b1;
      end else begin
        wr_wrd_q <= wr_wrd_q + 1'b1;
      end
    end
  end

`ifdef DMA_EXT_DEVICE_LFSR_EN
  logic [LfsrWidth-1:0] lfsr_next;
  logic                 unused_lfsr;

  dma_ext_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .load_i (1'b0),
    .step_i (wr_en),
    .next_o (lfsr_next)
  );

  assign wr_data     = lfsr_next[WORD_SIZE-1:0];
  assign unused_lfsr = ^lfsr_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        for (int j = 0; j < BURST_LEN; j++) begin
          mem_q[i][j] <= '0;
        end
      end
    end else if (wr_en) begin
      mem_q[wr_blk_q][wr_wrd_q] <= wr_data;
    end
  end
`else
  logic unused_seed;

  assign unused_seed = ^SEED;
  assign wr_data     = mem_q[wr_blk_q][wr_wrd_q] + WORD_SIZE'(NUM_BLOCKS * BURST_LEN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        for (int j = 0; j < BURST_LEN; j++) begin
          mem_q[i][j] <= WORD_SIZE'(i * BURST_LEN + j + 1);
        end
      end
    end else if (wr_en) begin
      mem_q[wr_blk_q][wr_wrd_q] <= wr_data;
    end
  end
`endif

  assign rd_blk = bus.offset[BLK_W-1:0];

  always_comb begin
    rd_block = '0;
    for (int j = 0; j < BURST_LEN; j++) begin
      rd_block[j*WORD_SIZE +: WORD_SIZE] = mem_q[rd_blk][j];
    end
  end

  // Reads sample pre-edge storage, so a same-edge write is not visible until the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q       <= '0;
      data_valid_q <= 1'b0;
      rd_err_q     <= 1'b0;
    end else if (state_q == StRefill || state_q == StInit) begin
      data_valid_q <= 1'b0;
    end else if (bus.offset >= OFFSET_W'(NUM_BLOCKS)) begin
      data_q       <= '0;
      data_valid_q <= 1'b1;
      rd_err_q     <= 1'b1;
    end else begin
      data_q       <= rd_block;
      data_valid_q <= 1'b1;
      rd_err_q     <= 1'b0;
    end
  end

  assign bus.interrupt  = irq_q;
  assign bus.data       = data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.rd_err     = rd_err_q;
  assign bus.missed     = missed_q;
  assign bus.halted     = halted_q;

endmodule

// File: tb/tb_dma_ext_device.sv
// tb_dma_ext_device: randomized stimulus against an event-level reference model with a scoreboard.
module tb_dma_ext_device;

  localparam int unsigned WS   = 16;
  localparam int unsigned BL   = 4;
  localparam int unsigned NB   = 3;
  localparam int unsigned FP   = 260;
  localparam int unsigned ID   = 100;
  localparam int unsigned NF   = 2;
  localparam logic [31:0] SEED = 32'h1;
  localparam int unsigned NW   = NB * BL;
  localparam int unsigned OW   = 2;

  localparam int PIdle = 0, PFire = 1, PBusy = 2, PRefill = 3, PHalt = 4, PInit = 5;

  typedef struct {
    int unsigned       cyc;
    logic [BL*WS-1:0]  data;
    logic              valid;
    logic              err;
    logic              intr;
    logic              halted;
    logic [7:0]        missed;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  dma_ext_device_if #(.WORD_SIZE(WS), .BURST_LEN(BL), .OFFSET_W(OW)) bus ();

  dma_ext_device #(
    .WORD_SIZE    (WS),
    .BURST_LEN    (BL),
    .NUM_BLOCKS   (NB),
    .FIRE_PERIOD  (FP),
    .INT_DURATION (ID),
    .NUM_FIRES    (NF),
    .SEED         (SEED)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: event phases with cycle counts; storage is a flat word array.
  int               m_phase, m_cnt, m_fires;
  logic [7:0]       m_missed;
  logic             m_int, m_halt, m_valid, m_err;
  logic [BL*WS-1:0] m_data;
  logic [WS-1:0]    m_store[NW];
  logic [31:0]      m_lfsr;

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) n = n ^ 32'h80200003;
    return n;
  endfunction

  // Words are never readable mid-refill, so the whole refill is applied at once.
  task automatic model_fill(input bit is_init);
    for (int k = 0; k < NW; k++) begin
`ifdef DMA_EXT_DEVICE_LFSR_EN
      m_lfsr     = ref_step(m_lfsr);
      m_store[k] = m_lfsr[WS-1:0];
`else
      m_store[k] = is_init ? WS'(k + 1) : m_store[k] + WS'(NW);
`endif
    end
  endtask

  task automatic model_step(input bit rst, input int off, input bit ack, input bit done);
    if (rst) begin
`ifdef DMA_EXT_DEVICE_LFSR_EN
      m_phase = PInit;
`else
      m_phase = PIdle;
`endif
      m_cnt = 0; m_fires = 0; m_missed = 0; m_int = 0; m_halt = 0;
      m_data = '0; m_valid = 0; m_err = 0;
      m_lfsr = SEED;
      model_fill(1'b1);
      return;
    end
    if (m_phase == PRefill || m_phase == PInit) begin
      m_valid = 0;
    end else if (off >= NB) begin
      m_data = '0; m_err = 1; m_valid = 1;
    end else begin
      for (int j = 0; j < BL; j++) m_data[j*WS +: WS] = m_store[off*BL + j];
      m_err = 0; m_valid = 1;
    end
    case (m_phase)
      PIdle: if (m_cnt == FP - 1) begin m_phase = PFire; m_cnt = 0; m_int = 1; end
             else m_cnt++;
      PFire: begin
        if (ack) begin
          m_phase = PBusy; m_cnt = 0; m_int = 0;
        end else if (m_cnt == ID - 1) begin
          if (m_missed != 8'hff) m_missed++;
          m_phase = PRefill; m_cnt = 0; m_int = 0;
        end else m_cnt++;
      end
      PBusy: if (done) begin m_phase = PRefill; m_cnt = 0; end
             else m_cnt++;
      PRefill: begin
        if (m_cnt == NW - 1) begin
          model_fill(1'b0);
          m_fires++; m_cnt = 0;
          if (m_fires == NF) begin m_phase = PHalt; m_halt = 1; end
          else m_phase = PIdle;
        end else m_cnt++;
      end
      PInit: if (m_cnt == NW - 1) begin m_phase = PIdle; m_cnt = 0; end
             else m_cnt++;
      default: ;
    endcase
  endtask

  task automatic drive(input bit rst, input int off, input bit ack, input bit done);
    @(negedge clk);
    #1;
    reset        = rst;
    bus.offset   = OW'(off);
    bus.int_ack  = ack;
    bus.dma_done = done;
    model_step(rst, off, ack, done);
    exp_q.push_back('{cyc: cyc + 1, data: m_data, valid: m_valid, err: m_err, intr: m_int,
                      halted: m_halt, missed: m_missed});
  endtask

  // ack_at < 0 means never acknowledge; spurious pulses are sprinkled where they must be ignored.
  task automatic step_rand(input int ack_at, input int done_dly);
    bit ack, done;
    ack  = (m_phase == PFire) && (ack_at >= 0) && (m_cnt == ack_at);
    done = (m_phase == PBusy) && (m_cnt == done_dly);
    if (m_phase != PFire && $urandom_range(0, 15) == 0) ack = 1'b1;
    if (m_phase != PBusy && $urandom_range(0, 15) == 0) done = 1'b1;
    drive(1'b0, int'($urandom_range(0, 3)), ack, done);
  endtask

  task automatic run_until_fires(input int ack_at, input int done_dly, input int target);
    int n;
    n = 0;
    while (m_fires < target && n < 3000) begin
      step_rand(ack_at, done_dly);
      n++;
    end
    if (m_fires < target) begin
      checks++; errors++;
      $display("FAIL event_budget: fires %0d after %0d cycles, required %0d", m_fires, n, target);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp,
                     input int unsigned c);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, c, act, exp);
    end
  endtask

  // Monitor: every edge presents a response; compare it against the entry queued for that edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        chk("data_valid", 64'(bus.data_valid), 64'(e.valid), e.cyc);
        chk("data", 64'(bus.data), 64'(e.data), e.cyc);
        chk("rd_err", 64'(bus.rd_err), 64'(e.err), e.cyc);
        chk("interrupt", 64'(bus.interrupt), 64'(e.intr), e.cyc);
        chk("missed", 64'(bus.missed), 64'(e.missed), e.cyc);
        chk("halted", 64'(bus.halted), 64'(e.halted), e.cyc);
      end
    end
  end

  initial begin
    int n;
    bus.offset   = '0;
    bus.int_ack  = 1'b0;
    bus.dma_done = 1'b0;
    repeat (3) drive(1'b1, 0, 1'b0, 1'b0);
`ifdef DMA_EXT_DEVICE_LFSR_EN
    repeat (NW) drive(1'b0, 0, 1'b0, 1'b0);
`endif
    for (int o = 0; o < 4; o++) drive(1'b0, o, 1'b0, 1'b0);

    // Event 1 times out; event 2 acks on the very cycle of the timeout.
    run_until_fires(-1, 0, 1);
    run_until_fires(ID - 1, int'($urandom_range(0, 30)), 2);
    repeat (1000) step_rand(-1, 0);

    // Reset mid-refill after an acked event, then read back the reset pattern.
    repeat (2) drive(1'b1, 0, 1'b0, 1'b0);
    n = 0;
    while (!(m_phase == PRefill && m_cnt == 5) && n < 3000) begin
      step_rand(4, 20);
      n++;
    end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL refill_budget: no refill after %0d cycles, required one", n);
    end
    repeat (2) drive(1'b1, 0, 1'b0, 1'b0);
    repeat (40) step_rand(-1, 0);

    run_until_fires(int'($urandom_range(0, ID - 2)), int'($urandom_range(0, 30)), 1);
    repeat (20) step_rand(-1, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
